atm_session_ctrl: RTL and testbench

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

---
 rtl/atm_pkg.sv | 23 ++
 rtl/atm_session_ctrl_if.sv | 45 ++++
 rtl/atm_timer.sv | 34 +++
 rtl/atm_session_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types for the ATM session controller
//
// Purpose: operation codes and FSM state encoding used by atm_session_ctrl.
// Ports:   none (package).
package atm_pkg;

   typedef enum logic [1:0] {
      OP_WITHDRAW = 2'b00,
      OP_DEPOSIT  = 2'b01,
      OP_INQUIRY  = 2'b10,
      OP_TRANSFER = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_AUTH  = 3'd1,
      S_MENU  = 3'd2,
      S_EXEC  = 3'd3,
      S_DONE  = 3'd4,
      S_EJECT = 3'd5
   } state_e;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// rtl/atm_session_ctrl_if.sv - signal bundle for the ATM session controller
//
// Purpose: groups the configuration, card, password, operation and result
//          signals of atm_session_ctrl (clock and reset stay separate).
// Modports: master - drives requests, observes results (terminal side)
//           slave  - receives requests, drives results (controller side)
interface atm_session_ctrl_if #(
   parameter int PSW_W  = 4,
   parameter int BAL_W  = 20,
   parameter int CARD_W = 3
);
   logic              cfg_we;
   logic [CARD_W-1:0] cfg_card;
   logic [PSW_W-1:0]  cfg_psw;
   logic [BAL_W-1:0]  cfg_bal;
   logic              card_in;
   logic [CARD_W-1:0] card_number;
   logic              psw_valid;
   logic [PSW_W-1:0]  password_input;
   logic              op_valid;
   logic [1:0]        operation;
   logic [BAL_W-1:0]  value;
   logic [CARD_W-1:0] dest_card;
   logic              another_service;
   logic [BAL_W-1:0]  updated_balance;
   logic              op_done;
   logic              error;
   logic              wrong_psw;
   logic              card_locked;
   logic              card_eject;

   modport master (
      output cfg_we, cfg_card, cfg_psw, cfg_bal, card_in, card_number,
             psw_valid, password_input, op_valid, operation, value,
             dest_card, another_service,
      input  updated_balance, op_done, error, wrong_psw, card_locked, card_eject
   );

   modport slave (
      input  cfg_we, cfg_card, cfg_psw, cfg_bal, card_in, card_number,
             psw_valid, password_input, op_valid, operation, value,
             dest_card, another_service,
      output updated_balance, op_done, error, wrong_psw, card_locked, card_eject
   );
endinterface

// File: rtl/atm_timer.sv
// rtl/atm_timer.sv - idle-cycle timeout counter
//
// Purpose: counts cycles since the last clear; expired is high once
//          TIMEOUT_CYC cycles have elapsed (so an FSM acting on it leaves
//          on the TIMEOUT_CYC-th edge after the clear).
// Ports:   clk, rst (async active-low), clear (restart count), expired.
module atm_timer #(
   parameter int TIMEOUT_CYC = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

   // Hold at the terminal value so a stalled consumer cannot wrap the count.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (!expired)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM card session controller
//
// Purpose: per-account password/balance/lock store plus a session FSM
//          (IDLE, AUTH, MENU, EXEC, DONE, EJECT) handling card insertion,
//          password retries with lockout, withdraw/deposit/inquiry/transfer
//          and inactivity timeout.
// Ports:   clk, rst (async active-low); cfg_* account load (IDLE only);
//          card_in/card_number; psw_valid/password_input;
//          op_valid/operation/value/dest_card; another_service;
//          updated_balance and one-cycle registered pulses op_done, error,
//          wrong_psw, card_locked, card_eject.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int PSW_W       = 4,
   parameter int BAL_W       = 20,
   parameter int CARD_W      = 3,
   parameter int USERS       = 7,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [CARD_W-1:0] cfg_card,
   input  logic [PSW_W-1:0]  cfg_psw,
   input  logic [BAL_W-1:0]  cfg_bal,
   input  logic              card_in,
   input  logic [CARD_W-1:0] card_number,
   input  logic              psw_valid,
   input  logic [PSW_W-1:0]  password_input,
   input  logic              op_valid,
   input  logic [1:0]        operation,
   input  logic [BAL_W-1:0]  value,
   input  logic [CARD_W-1:0] dest_card,
   input  logic              another_service,
   output logic [BAL_W-1:0]  updated_balance,
   output logic              op_done,
   output logic              error,
   output logic              wrong_psw,
   output logic              card_locked,
   output logic              card_eject
);
   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam logic [CARD_W:0] USERS_L = (CARD_W + 1)'(USERS);

   function automatic logic in_range(input logic [CARD_W-1:0] idx);
      return {1'b0, idx} < USERS_L;
   endfunction

   logic [PSW_W-1:0]  psw_q   [USERS];
   logic [BAL_W-1:0]  bal_q   [USERS];
   logic [TW-1:0]     tries_q [USERS];
   logic [USERS-1:0]  lock_q;

   state_e            state_q, state_d;
   logic [CARD_W-1:0] sess_q, sess_d, dst_q, dst_d;
   op_e               op_q, op_d;
   logic [BAL_W-1:0]  val_q, val_d, upd_q, upd_d;
   logic              ok_q, ok_d;
   logic              op_done_q, op_done_d, error_q, error_d;
   logic              wrong_psw_q, wrong_psw_d, card_locked_q, card_locked_d;
   logic              card_eject_q, card_eject_d;

   logic              cfg_wr, tries_wr, lock_set, src_wr, dst_wr;
   logic [TW-1:0]     tries_new, tries_inc;
   logic [BAL_W-1:0]  src_new, dst_new;
   logic [BAL_W:0]    src_ext, dst_ext, val_ext, src_add, src_sub, dst_add;
   logic              short_funds, timer_clear, expired;

   atm_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .expired (expired)
   );

   always_comb begin
      // One extra bit so overflow/underflow shows up in the MSB.
      src_ext     = {1'b0, bal_q[sess_q]};
      dst_ext     = {1'b0, bal_q[dst_q]};
      val_ext     = {1'b0, val_q};
      src_add     = src_ext + val_ext;
      src_sub     = src_ext - val_ext;
      dst_add     = dst_ext + val_ext;
      short_funds = val_ext > src_ext;
      tries_inc   = tries_q[sess_q] + TW'(1);

      state_d = state_q;   sess_d = sess_q;  op_d = op_q;
      val_d   = val_q;     dst_d  = dst_q;   ok_d = ok_q;  upd_d = upd_q;
      op_done_d = 1'b0;  error_d = 1'b0;  wrong_psw_d = 1'b0;  card_locked_d = 1'b0;
      cfg_wr = 1'b0;  tries_wr = 1'b0;  tries_new = '0;  lock_set = 1'b0;
      src_wr = 1'b0;  dst_wr = 1'b0;
      src_new = src_sub[BAL_W-1:0];
      dst_new = dst_add[BAL_W-1:0];

      case (state_q)
         S_IDLE: begin
            // Account load takes precedence over a simultaneous insertion.
            if (cfg_we) begin
               cfg_wr = in_range(cfg_card);
            end else if (card_in) begin
               if (!in_range(card_number)) begin
                  error_d = 1'b1;
                  state_d = S_EJECT;
               end else if (lock_q[card_number]) begin
                  card_locked_d = 1'b1;
                  state_d       = S_EJECT;
               end else begin
                  sess_d  = card_number;
                  state_d = S_AUTH;
               end
            end
         end
         S_AUTH: begin
            if (psw_valid) begin
               tries_wr = 1'b1;
               if (password_input == psw_q[sess_q]) begin
                  state_d = S_MENU;
               end else begin
                  wrong_psw_d = 1'b1;
                  tries_new   = tries_inc;
                  if (tries_inc >= TW'(MAX_TRIES)) begin
                     lock_set      = 1'b1;
                     card_locked_d = 1'b1;
                     state_d       = S_EJECT;
                  end
               end
            end else if (expired) begin
               state_d = S_EJECT;
            end
         end
         S_MENU: begin
            if (op_valid) begin
               op_d    = op_e'(operation);
               val_d   = value;
               dst_d   = dest_card;
               state_d = S_EXEC;
            end else if (expired) begin
               state_d = S_EJECT;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_WITHDRAW: ok_d = !short_funds;
               OP_DEPOSIT: begin
                  ok_d    = !src_add[BAL_W];
                  src_new = src_add[BAL_W-1:0];
               end
               OP_INQUIRY:  ok_d = 1'b1;
               OP_TRANSFER: ok_d = in_range(dst_q) && (dst_q != sess_q) &&
                                   !short_funds && !dst_add[BAL_W];
               default:     ok_d = 1'b0;
            endcase
            src_wr  = ok_d && (op_q != OP_INQUIRY);
            dst_wr  = ok_d && (op_q == OP_TRANSFER);
            state_d = S_DONE;
         end
         S_DONE: begin
            op_done_d = ok_q;
            error_d   = !ok_q;
            upd_d     = bal_q[sess_q];
            state_d   = another_service ? S_MENU : S_EJECT;
         end
         S_EJECT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      card_eject_d = (state_d == S_EJECT);
      // Timer runs only while waiting for a strobe in AUTH/MENU.
      timer_clear  = !((state_q == S_AUTH) || (state_q == S_MENU)) ||
                     ((state_q == S_AUTH) && psw_valid) ||
                     ((state_q == S_MENU) && op_valid) ||
                     (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;  sess_q <= '0;  dst_q <= '0;  op_q <= OP_WITHDRAW;
         val_q <= '0;  upd_q <= '0;  ok_q <= 1'b0;
         op_done_q <= 1'b0;  error_q <= 1'b0;  wrong_psw_q <= 1'b0;
         card_locked_q <= 1'b0;  card_eject_q <= 1'b0;
         lock_q <= '0;
         for (int i = 0; i < USERS; i++) begin
            psw_q[i]   <= '0;
            bal_q[i]   <= '0;
            tries_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;  sess_q <= sess_d;  dst_q <= dst_d;  op_q <= op_d;
         val_q <= val_d;  upd_q <= upd_d;  ok_q <= ok_d;
         op_done_q <= op_done_d;  error_q <= error_d;  wrong_psw_q <= wrong_psw_d;
         card_locked_q <= card_locked_d;  card_eject_q <= card_eject_d;
         if (cfg_wr) begin
            psw_q[cfg_card]   <= cfg_psw;
            bal_q[cfg_card]   <= cfg_bal;
            tries_q[cfg_card] <= '0;
            lock_q[cfg_card]  <= 1'b0;
         end
         if (tries_wr) tries_q[sess_q] <= tries_new;
         if (lock_set) lock_q[sess_q]  <= 1'b1;
         if (src_wr)   bal_q[sess_q]   <= src_new;
         if (dst_wr)   bal_q[dst_q]    <= dst_new;
      end
   end

   assign updated_balance = upd_q;
   assign op_done         = op_done_q;
   assign error           = error_q;
   assign wrong_psw       = wrong_psw_q;
   assign card_locked     = card_locked_q;
   assign card_eject      = card_eject_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - self-checking bench for atm_session_ctrl
module tb_atm_session_ctrl;
   localparam int PSW_W = 4, BAL_W = 20, CARD_W = 3, USERS = 7;
   localparam int MAX_TRIES = 3, TIMEOUT_CYC = 10;
   localparam longint MAXB = (64'd1 << BAL_W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   atm_session_ctrl_if #(.PSW_W(PSW_W), .BAL_W(BAL_W), .CARD_W(CARD_W)) bus ();

   atm_session_ctrl #(
      .PSW_W(PSW_W), .BAL_W(BAL_W), .CARD_W(CARD_W), .USERS(USERS),
      .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_we(bus.cfg_we), .cfg_card(bus.cfg_card), .cfg_psw(bus.cfg_psw),
      .cfg_bal(bus.cfg_bal), .card_in(bus.card_in), .card_number(bus.card_number),
      .psw_valid(bus.psw_valid), .password_input(bus.password_input),
      .op_valid(bus.op_valid), .operation(bus.operation), .value(bus.value),
      .dest_card(bus.dest_card), .another_service(bus.another_service),
      .updated_balance(bus.updated_balance), .op_done(bus.op_done),
      .error(bus.error), .wrong_psw(bus.wrong_psw),
      .card_locked(bus.card_locked), .card_eject(bus.card_eject)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference account store
   longint m_bal   [USERS];
   int     m_psw   [USERS];
   bit     m_lock  [USERS];
   int     m_tries [USERS];

   typedef struct {
      bit     fresh;
      int     card;
      int     pw;
      int     op;
      longint val;
      int     dest;
      bit     another;
      bit     ok;
      longint upd;
   } vec_t;
   vec_t vt[13];

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // exp bits: {op_done, error, wrong_psw, card_locked, card_eject}
   task automatic pulses(input string name, input logic [4:0] exp);
      chk(name, {59'd0, bus.op_done, bus.error, bus.wrong_psw, bus.card_locked,
                 bus.card_eject}, {59'd0, exp});
   endtask

   task automatic model_reset();
      for (int i = 0; i < USERS; i++) begin
         m_bal[i] = 0; m_psw[i] = 0; m_lock[i] = 0; m_tries[i] = 0;
      end
   endtask

   task automatic cfg(input int card, input int pw, input longint bal);
      bus.cfg_we = 1'b1; bus.cfg_card = CARD_W'(card);
      bus.cfg_psw = PSW_W'(pw); bus.cfg_bal = BAL_W'(bal);
      cycle();
      bus.cfg_we = 1'b0;
      if (card < USERS) begin
         m_psw[card] = pw; m_bal[card] = bal; m_lock[card] = 0; m_tries[card] = 0;
      end
   endtask

   task automatic insert(input int card);
      bus.card_in = 1'b1; bus.card_number = CARD_W'(card);
      cycle();
      bus.card_in = 1'b0;
      if (card >= USERS) begin
         pulses("insert_bad_card", 5'b01001); cycle();
      end else if (m_lock[card]) begin
         pulses("insert_locked", 5'b00011); cycle();
      end else begin
         pulses("insert_ok", 5'b00000);
      end
   endtask

   // st: 0 still authenticating, 1 in menu, 2 ejected (back in idle)
   task automatic enter_psw(input int card, input int pw, output int st);
      bus.psw_valid = 1'b1; bus.password_input = PSW_W'(pw);
      cycle();
      bus.psw_valid = 1'b0;
      if (pw == m_psw[card]) begin
         m_tries[card] = 0; st = 1;
         pulses("psw_ok", 5'b00000);
      end else begin
         m_tries[card]++;
         if (m_tries[card] >= MAX_TRIES) begin
            m_lock[card] = 1; st = 2;
            pulses("psw_lockout", 5'b00111);
            cycle();
         end else begin
            st = 0;
            pulses("psw_wrong", 5'b00100);
         end
      end
   endtask

   task automatic m_exec(input int s, input int op, input longint val, input int dest,
                         output bit ok);
      ok = 1'b1;
      case (op)
         0: if (val > m_bal[s]) ok = 1'b0; else m_bal[s] -= val;
         1: if (m_bal[s] + val > MAXB) ok = 1'b0; else m_bal[s] += val;
         3: if (dest >= USERS || dest == s || val > m_bal[s] || m_bal[dest] + val > MAXB)
               ok = 1'b0;
            else begin
               m_bal[s] -= val; m_bal[dest] += val;
            end
         default: ;
      endcase
   endtask

   task automatic do_op(input int op, input longint val, input int dest, input bit another,
                        input bit ok, input longint upd);
      bus.op_valid = 1'b1; bus.operation = 2'(op);
      bus.value = BAL_W'(val); bus.dest_card = CARD_W'(dest);
      cycle();
      bus.op_valid = 1'b0;
      pulses("op_accept_quiet", 5'b00000);
      cycle();
      bus.another_service = another;
      pulses("op_exec_quiet", 5'b00000);
      cycle();
      bus.another_service = 1'b0;
      pulses("op_result", {ok, !ok, 2'b00, !another});
      chk("updated_balance", {44'd0, bus.updated_balance}, upd);
      if (!another) cycle();
   endtask

   task automatic wait_eject(input string name);
      int n;
      n = 0;
      while (bus.card_eject !== 1'b1 && n < 4 * TIMEOUT_CYC) begin
         cycle(); n++;
      end
      chk(name, n, TIMEOUT_CYC);
      pulses({name, "_pulses"}, 5'b00001);
      cycle();
   endtask

   function automatic longint pick_val(input longint b);
      longint v;
      case ($urandom_range(0, 3))
         0:       v = longint'($urandom_range(0, 1000));
         1:       v = b;
         2:       v = (b < MAXB) ? b + 1 : b;
         default: v = longint'($urandom_range(0, 32'(MAXB)));
      endcase
      return v;
   endfunction

   task automatic run_random(input int sessions);
      int card, st, nops, op, dest;
      longint val, bal;
      bit ok, another;
      for (int c = 0; c < USERS; c++) begin
         if ($urandom_range(0, 3) == 0) bal = MAXB - longint'($urandom_range(0, 200));
         else                           bal = longint'($urandom_range(0, 600000));
         cfg(c, int'($urandom_range(0, 15)), bal);
      end
      for (int s = 0; s < sessions; s++) begin
         card = int'($urandom_range(0, USERS - 1));
         insert(card);
         if ($urandom_range(0, 3) == 0) enter_psw(card, m_psw[card] ^ 1, st);
         enter_psw(card, m_psw[card], st);
         nops = int'($urandom_range(1, 3));
         for (int k = 0; k < nops; k++) begin
            op      = int'($urandom_range(0, 3));
            dest    = int'($urandom_range(0, 7));
            val     = pick_val(m_bal[card]);
            another = (k != nops - 1);
            m_exec(card, op, val, dest, ok);
            do_op(op, val, dest, another, ok, m_bal[card]);
         end
      end
   endtask

   initial begin : main
      int st;
      bit okm;
      bus.cfg_we = 0; bus.cfg_card = 0; bus.cfg_psw = 0; bus.cfg_bal = 0;
      bus.card_in = 0; bus.card_number = 0; bus.psw_valid = 0; bus.password_input = 0;
      bus.op_valid = 0; bus.operation = 0; bus.value = 0; bus.dest_card = 0;
      bus.another_service = 0;
      model_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      pulses("reset_pulses", 5'b00000);
      chk("reset_updated_balance", {44'd0, bus.updated_balance}, 0);
      cycle(); cycle();
      rst = 1'b1;

      cfg(0, 4'h3, 500);
      cfg(1, 4'h5, 77);
      cfg(2, 4'hA, 300);
      cfg(3, 4'h6, 1048500);
      cfg(5, 4'hF, 500);

      vt[0]  = '{1, 0, 4'h3, 0, 100,     0, 0, 1, 400};
      vt[1]  = '{1, 2, 4'hA, 3, 100,     3, 1, 0, 300};
      vt[2]  = '{0, 2, 4'hA, 3, 50,      3, 0, 1, 250};
      vt[3]  = '{1, 3, 4'h6, 2, 0,       0, 0, 1, 1048550};
      vt[4]  = '{1, 5, 4'hF, 0, 600,     0, 1, 0, 500};
      vt[5]  = '{0, 5, 4'hF, 2, 0,       0, 1, 1, 500};
      vt[6]  = '{0, 5, 4'hF, 1, 1048076, 0, 1, 0, 500};
      vt[7]  = '{0, 5, 4'hF, 1, 1048075, 0, 1, 1, 1048575};
      vt[8]  = '{0, 5, 4'hF, 0, 1048575, 0, 1, 1, 0};
      vt[9]  = '{0, 5, 4'hF, 3, 0,       5, 1, 0, 0};
      vt[10] = '{0, 5, 4'hF, 3, 0,       7, 0, 0, 0};
      vt[11] = '{1, 2, 4'hA, 3, 250,     0, 0, 1, 0};
      vt[12] = '{1, 0, 4'h3, 2, 0,       0, 0, 1, 650};
      for (int i = 0; i < 13; i++) begin
         if (vt[i].fresh) begin
            insert(vt[i].card);
            enter_psw(vt[i].card, vt[i].pw, st);
         end
         m_exec(vt[i].card, vt[i].op, vt[i].val, vt[i].dest, okm);
         do_op(vt[i].op, vt[i].val, vt[i].dest, vt[i].another, vt[i].ok, vt[i].upd);
      end

      // Lockout after repeated wrong passwords, then refused reinsertion
      insert(1);
      for (int i = 0; i < MAX_TRIES; i++) enter_psw(1, 0, st);
      insert(1);
      pulses("idle_after_locked", 5'b00000);

      // Simultaneous load and insertion: load wins and clears the lock
      bus.cfg_we = 1'b1; bus.cfg_card = 3'd1; bus.cfg_psw = 4'h5; bus.cfg_bal = 20'd77;
      bus.card_in = 1'b1; bus.card_number = 3'd1;
      cycle();
      bus.cfg_we = 1'b0; bus.card_in = 1'b0;
      pulses("cfg_wins_cycle0", 5'b00000);
      cycle();
      pulses("cfg_wins_cycle1", 5'b00000);
      m_psw[1] = 5; m_bal[1] = 77; m_lock[1] = 0; m_tries[1] = 0;
      insert(1);
      enter_psw(1, 5, st);
      do_op(2, 0, 0, 0, 1, 77);

      insert(7);

      // Inactivity timeouts
      insert(0);
      wait_eject("auth_timeout");
      insert(0);
      enter_psw(0, 3, st);
      wait_eject("menu_timeout");

      // Reset while a deposit is executing
      insert(0);
      enter_psw(0, 3, st);
      bus.op_valid = 1'b1; bus.operation = 2'd1; bus.value = 20'd10; bus.dest_card = 0;
      cycle();
      bus.op_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      pulses("rst_exec_pulses", 5'b00000);
      chk("rst_exec_updated_balance", {44'd0, bus.updated_balance}, 0);
      cycle(); cycle();
      rst = 1'b1;
      model_reset();
      cycle();
      pulses("post_reset_quiet", 5'b00000);
      insert(0);
      enter_psw(0, 0, st);
      do_op(2, 0, 0, 0, 1, 0);
      insert(3);
      enter_psw(3, 0, st);
      do_op(2, 0, 0, 0, 1, 0);

      run_random(30);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog");
   end
endmodule
